// File: rtl/demux_1x8_seq_if.sv
// rtl/demux_1x8_seq_if.sv - sample stream in, committed eight-channel frame out
interface demux_1x8_seq_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] y;
  logic             y_valid;
  logic             auto_en;
  logic             s0;
  logic             s1;
  logic             s2;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] e;
  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] h;
  logic             frame_valid;
  logic [2:0]       slot;
  logic             busy;

  modport master (
    output y, y_valid, auto_en, s0, s1, s2,
    input  a, b, c, d, e, f, g, h, frame_valid, slot, busy
  );

  modport slave (
    input  y, y_valid, auto_en, s0, s1, s2,
    output a, b, c, d, e, f, g, h, frame_valid, slot, busy
  );
endinterface

// File: rtl/demux_1x8_seq.sv
// rtl/demux_1x8_seq.sv - registered 1-to-8 demux committing whole frames
module demux_1x8_seq #(
  parameter int             WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic            clk,
  input logic            rst,
  demux_1x8_seq_if.slave bus
);

  logic [WIDTH-1:0] staging [8];
  logic [WIDTH-1:0] frame   [8];
  logic [WIDTH-1:0] frame_next [8];
  logic [7:0]       mask;
  logic [2:0]       slot_cnt;
  logic             auto_q;
  logic             frame_pulse;

  logic             mode_change;
  logic [7:0]       base_mask;
  logic [2:0]       base_slot;
  logic [2:0]       idx;
  logic [7:0]       mask_acc;
  logic             commit;

  // A mode change discards the partial frame, so the current edge starts
  // from an empty mask and slot 0; the frame image includes the incoming y.
  always_comb begin
    mode_change = bus.auto_en != auto_q;
    base_mask   = mode_change ? 8'h00 : mask;
    base_slot   = mode_change ? 3'd0 : slot_cnt;
    idx         = bus.auto_en ? base_slot : {bus.s2, bus.s1, bus.s0};
    mask_acc    = base_mask | (8'h01 << idx);
    commit      = bus.y_valid && (mask_acc == 8'hFF);
    for (int i = 0; i < 8; i++) begin
      frame_next[i] = (3'(i) == idx) ? bus.y : staging[i];
    end
  end

  // Staging, mask, slot counter and committed outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        staging[i] <= RESET_VAL;
        frame[i]   <= RESET_VAL;
      end
      mask        <= 8'h00;
      slot_cnt    <= 3'd0;
      auto_q      <= 1'b0;
      frame_pulse <= 1'b0;
    end else begin
      auto_q      <= bus.auto_en;
      frame_pulse <= 1'b0;
      if (bus.y_valid) begin
        staging[idx] <= bus.y;
        slot_cnt     <= bus.auto_en ? base_slot + 3'd1 : base_slot;
        if (commit) begin
          for (int i = 0; i < 8; i++) begin
            frame[i] <= frame_next[i];
          end
          mask        <= 8'h00;
          frame_pulse <= 1'b1;
        end else begin
          mask <= mask_acc;
        end
      end else begin
        mask     <= base_mask;
        slot_cnt <= base_slot;
      end
    end
  end

  assign bus.a           = frame[0];
  assign bus.b           = frame[1];
  assign bus.c           = frame[2];
  assign bus.d           = frame[3];
  assign bus.e           = frame[4];
  assign bus.f           = frame[5];
  assign bus.g           = frame[6];
  assign bus.h           = frame[7];
  assign bus.frame_valid = frame_pulse;
  assign bus.slot        = slot_cnt;
  assign bus.busy        = |mask;

endmodule

// File: tb/tb_demux_1x8_seq.sv
// tb/tb_demux_1x8_seq.sv - table and scoreboard bench for demux_1x8_seq
module tb_demux_1x8_seq;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  bit [7:0] sb[$];

  demux_1x8_seq_if #(.WIDTH(1)) bus();

  demux_1x8_seq #(.WIDTH(1), .RESET_VAL(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       v;
    bit       au;
    bit [2:0] sel;
    bit       y;
    bit       efv;
    bit       ebusy;
    bit [2:0] eslot;
    bit [7:0] frm;
  } vec_t;

  function automatic bit [7:0] frame_now();
    return {bus.h, bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle, push the expected frame if this sample completes one,
  // then check pulse/busy/slot just after the edge.
  task automatic drive(input bit v, input bit au, input bit [2:0] sel, input bit yy,
                       input bit efv, input bit ebusy, input bit [2:0] eslot,
                       input bit push, input bit [7:0] frm, input string tag);
    bus.y_valid = v;
    bus.auto_en = au;
    {bus.s2, bus.s1, bus.s0} = sel;
    bus.y = yy;
    if (push) sb.push_back(frm);
    @(posedge clk);
    #1;
    check({tag, " frame_valid"}, 32'(bus.frame_valid), 32'(efv));
    check({tag, " busy"}, 32'(bus.busy), 32'(ebusy));
    check({tag, " slot"}, 32'(bus.slot), 32'(eslot));
  endtask

  // Scoreboard: every frame_valid pulse must match the oldest expected frame.
  always @(negedge clk) begin
    if (!rst && bus.frame_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_frame: got %0h expected none", frame_now());
      end else begin
        check("frame", 32'(frame_now()), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t     tbl [16];
    bit [7:0] t2y;
    bit [2:0] t3s [8];
    bit [15:0] r;
    total = 0;
    bad   = 0;
    t2y   = 8'b1101_0100;
    t3s   = '{3'd7, 3'd0, 3'd5, 3'd2, 3'd1, 3'd6, 3'd3, 3'd4};
    for (int i = 0; i < 8; i++) begin
      tbl[i] = '{v: 1'b1, au: 1'b1, sel: 3'd0, y: t2y[i], efv: (i == 7), ebusy: (i != 7),
                 eslot: 3'(i + 1), frm: 8'hD4};
      tbl[8 + i] = '{v: 1'b1, au: 1'b0, sel: t3s[i], y: t3s[i][0], efv: (i == 7),
                     ebusy: (i != 7), eslot: 3'd0, frm: 8'hAA};
    end

    rst = 1'b1;
    bus.y = 1'b0;
    bus.y_valid = 1'b0;
    bus.auto_en = 1'b0;
    {bus.s2, bus.s1, bus.s0} = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset frame", 32'(frame_now()), 32'h0);
    check("reset frame_valid", 32'(bus.frame_valid), 32'h0);
    check("reset busy", 32'(bus.busy), 32'h0);
    check("reset slot", 32'(bus.slot), 32'h0);

    // Auto frame then manual out-of-order frame from the table.
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].v, tbl[i].au, tbl[i].sel, tbl[i].y, tbl[i].efv, tbl[i].ebusy,
            tbl[i].eslot, tbl[i].efv, tbl[i].frm, $sformatf("vec%0d", i));
    end

    // Duplicate write to slot 3 with idle gaps; last value wins.
    drive(1, 0, 3'd3, 1, 0, 1, 0, 0, 8'h00, "dup w1");
    drive(0, 0, 3'd0, 0, 0, 1, 0, 0, 8'h00, "dup idle1");
    drive(0, 0, 3'd0, 0, 0, 1, 0, 0, 8'h00, "dup idle2");
    drive(1, 0, 3'd3, 0, 0, 1, 0, 0, 8'h00, "dup w2");
    drive(0, 0, 3'd0, 0, 0, 1, 0, 0, 8'h00, "dup idle3");
    foreach (t3s[k]) begin
      if (k < 6) drive(1, 0, (k < 3) ? 3'(k) : 3'(k + 1), 1, 0, 1, 0, 0, 8'h00, $sformatf("dup fill%0d", k));
    end
    drive(1, 0, 3'd7, 1, 1, 0, 0, 1, 8'hF7, "dup last");

    // Mode switch discards a partial auto frame; outputs hold.
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 3'd0, 1, 0, 1, 3'(i + 1), 0, 8'h00, $sformatf("ms auto%0d", i));
    end
    drive(0, 0, 3'd0, 0, 0, 0, 0, 0, 8'h00, "ms switch");
    check("ms frame hold", 32'(frame_now()), 32'hF7);
    for (int i = 0; i < 8; i++) begin
      bit [2:0] s;
      s = 3'(i);
      drive(1, 0, s, s[1], (i == 7), (i != 7), 0, (i == 7), 8'hCC, $sformatf("ms man%0d", i));
    end

    // Back-to-back auto frames: pulses on the 8th and 16th sample.
    r = 16'($urandom);
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 3'd0, r[i], (i % 8 == 7), (i % 8 != 7), 3'((i + 1) % 8),
            (i == 7) || (i == 15), (i < 8) ? r[7:0] : r[15:8], $sformatf("b2b%0d", i));
    end

    // Asynchronous reset in the middle of a partial auto frame.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 3'd0, 1, 0, 1, 3'(i + 1), 0, 8'h00, $sformatf("rs pre%0d", i));
    end
    bus.y_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async frame", 32'(frame_now()), 32'h0);
    check("async frame_valid", 32'(bus.frame_valid), 32'h0);
    check("async busy", 32'(bus.busy), 32'h0);
    check("async slot", 32'(bus.slot), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 3'd0, 1, (i == 7), (i != 7), 3'((i + 1) % 8), (i == 7), 8'hFF, $sformatf("rs post%0d", i));
    end
    drive(0, 1, 3'd0, 0, 0, 0, 0, 0, 8'h00, "final idle");
    @(negedge clk);
    check("scoreboard empty", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
